// File: rtl/VX_tensor_pkg.sv
// Shared definitions for the tensor issue arbiter.
// Holds the tile widths of one 4x4x2 tensor beat and the arbiter state type.
package VX_tensor_pkg;

  localparam int TILE_A_W = 256;  // [3:0][1:0][31:0]
  localparam int TILE_B_W = 256;  // [1:0][3:0][31:0]
  localparam int TILE_C_W = 512;  // [3:0][3:0][31:0]
  localparam int TILE_D_W = 512;  // [3:0][3:0][31:0]

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vx_tensor_tag_fifo.sv
// Tag FIFO for the tensor issue arbiter.
// Records {requester index, warp id} for every beat sent to the tensor unit.
// Responses come back in issue order, so the head entry says which requester
// owns the next D tile.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   i_push       - write i_push_data (ignored when full)
//   i_pop        - drop the head entry (ignored when empty)
//   o_head       - head entry, valid while !o_empty
//   o_empty      - no entries
//   o_full       - DEPTH entries
module vx_tensor_tag_fifo #(
  parameter int DATAW = 6,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [DATAW-1:0] i_push_data,
  input  logic             i_pop,
  output logic [DATAW-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/vx_tensor_issue_arb.sv
// Tensor issue arbiter.
// Shares one tensor threadgroups unit between NUM_REQS requesters. An HMMA
// instruction is a run of tile beats ending in a 'last' beat; the grant is
// held for the whole run, and runs are picked round-robin. In-flight beats
// are bounded by a credit counter, and D tiles are routed back to the
// requester that issued them through a tag FIFO.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   req_valid/ready/last       - per-requester beat handshake
//   req_A/B/C/wid              - per-requester beat payload
//   tu_valid/ready, tu_A/B/C/wid - muxed beat to the tensor unit
//   tu_rsp_valid/ready/D/wid   - D tile from the tensor unit
//   rsp_valid/ready, rsp_D/wid - D tile back to the owning requester
//   busy                       - beats outstanding or an instruction in progress
module vx_tensor_issue_arb
  import VX_tensor_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int MAX_INFLIGHT = 16,
  parameter int NW_WIDTH     = 4,
  parameter int REQ_BITS     = $clog2(NUM_REQS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 req_valid,
  output logic [NUM_REQS-1:0]                 req_ready,
  input  logic [NUM_REQS-1:0]                 req_last,
  input  logic [NUM_REQS-1:0][TILE_A_W-1:0]   req_A,
  input  logic [NUM_REQS-1:0][TILE_B_W-1:0]   req_B,
  input  logic [NUM_REQS-1:0][TILE_C_W-1:0]   req_C,
  input  logic [NUM_REQS-1:0][NW_WIDTH-1:0]   req_wid,
  output logic                                tu_valid,
  input  logic                                tu_ready,
  output logic [TILE_A_W-1:0]                 tu_A,
  output logic [TILE_B_W-1:0]                 tu_B,
  output logic [TILE_C_W-1:0]                 tu_C,
  output logic [NW_WIDTH-1:0]                 tu_wid,
  input  logic                                tu_rsp_valid,
  output logic                                tu_rsp_ready,
  input  logic [TILE_D_W-1:0]                 tu_rsp_D,
  input  logic [NW_WIDTH-1:0]                 tu_rsp_wid,
  output logic [NUM_REQS-1:0]                 rsp_valid,
  input  logic [NUM_REQS-1:0]                 rsp_ready,
  output logic [TILE_D_W-1:0]                 rsp_D,
  output logic [NW_WIDTH-1:0]                 rsp_wid,
  output logic                                busy
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int TAG_W = REQ_BITS + NW_WIDTH;

  arb_state_e          r_state;
  logic [REQ_BITS-1:0] r_rr_ptr;
  logic [REQ_BITS-1:0] r_lock_idx;
  logic [CNT_W-1:0]    r_inflight;

  logic [REQ_BITS-1:0] w_sel;
  logic                w_sel_valid;
  logic                w_can_issue;
  logic                w_fire;
  logic                w_rsp_fire;
  logic                w_tag_empty;
  logic                w_tag_full;
  logic [TAG_W-1:0]    w_tag_head;
  logic [REQ_BITS-1:0] w_head_idx;
  logic [NW_WIDTH-1:0] w_head_wid;
  logic                w_lock_hold;

  // First valid requester scanning circularly from ptr. With nothing valid it
  // returns ptr, whose valid bit is then 0, so no beat is offered.
  function automatic logic [REQ_BITS-1:0] rr_pick(input logic [NUM_REQS-1:0] v,
                                                  input logic [REQ_BITS-1:0] ptr);
    logic [REQ_BITS-1:0] pick;
    logic                found;
    int                  idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(ptr) + k) % NUM_REQS;
      if (!found && v[idx]) begin
        found = 1'b1;
        pick  = REQ_BITS'(idx);
      end
    end
    return pick;
  endfunction

  // A locked instruction keeps the grant even through requester bubbles so
  // the steps of one warp's HMMA stay contiguous at the tensor unit.
  assign w_sel       = (r_state == LOCKED) ? r_lock_idx : rr_pick(req_valid, r_rr_ptr);
  assign w_sel_valid = req_valid[w_sel];
  assign w_can_issue = (r_inflight < CNT_W'(MAX_INFLIGHT)) & ~w_tag_full;
  assign tu_valid    = w_can_issue & w_sel_valid;
  assign w_fire      = tu_valid & tu_ready;

  assign tu_A   = req_A[w_sel];
  assign tu_B   = req_B[w_sel];
  assign tu_C   = req_C[w_sel];
  assign tu_wid = req_wid[w_sel];

  // Ready only accompanies a beat that is actually taken this cycle.
  always_comb begin
    req_ready        = '0;
    req_ready[w_sel] = w_fire;
  end

  vx_tensor_tag_fifo #(
    .DATAW (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_fire),
    .i_push_data ({w_sel, req_wid[w_sel]}),
    .i_pop       (w_rsp_fire),
    .o_head      (w_tag_head),
    .o_empty     (w_tag_empty),
    .o_full      (w_tag_full)
  );

  assign w_head_idx = w_tag_head[TAG_W-1:NW_WIDTH];
  assign w_head_wid = w_tag_head[NW_WIDTH-1:0];

  always_comb begin
    rsp_valid             = '0;
    rsp_valid[w_head_idx] = tu_rsp_valid & ~w_tag_empty;
  end

  assign tu_rsp_ready = ~w_tag_empty & rsp_ready[w_head_idx];
  assign w_rsp_fire   = tu_rsp_valid & tu_rsp_ready;
  assign rsp_D        = tu_rsp_D;
  assign rsp_wid      = tu_rsp_wid;
  assign busy         = (r_inflight != '0) | (r_state == LOCKED);

  // A credit released by a response only becomes usable next cycle; there is
  // no same-cycle bypass into can_issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
      r_inflight <= '0;
    end else begin
      if (w_fire) begin
        if (req_last[w_sel]) begin
          r_state  <= IDLE;
          r_rr_ptr <= (w_sel == REQ_BITS'(NUM_REQS - 1)) ? '0 : w_sel + 1'b1;
        end else begin
          r_state    <= LOCKED;
          r_lock_idx <= w_sel;
        end
      end
      case ({w_fire, w_rsp_fire})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // The locked requester offered a beat that was not taken; it must keep it.
  assign w_lock_hold = (r_state == LOCKED) & req_valid[r_lock_idx] & ~w_fire;

  a_rsp_has_tag: assert property (@(posedge clk) disable iff (reset)
    !(tu_rsp_valid && w_tag_empty));

  a_rsp_wid_match: assert property (@(posedge clk) disable iff (reset)
    !(tu_rsp_valid && !w_tag_empty && (tu_rsp_wid != w_head_wid)));

  a_lock_valid_stable: assert property (@(posedge clk) disable iff (reset)
    !($past(w_lock_hold) && !req_valid[r_lock_idx]));

endmodule

// File: tb/tb_vx_tensor_issue_arb.sv
module tb_vx_tensor_issue_arb;
  localparam int NR = 4;
  localparam int MI = 4;
  localparam int NW = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NR-1:0]           req_valid, req_ready, req_last;
  logic [NR-1:0][255:0]    req_A, req_B;
  logic [NR-1:0][511:0]    req_C;
  logic [NR-1:0][NW-1:0]   req_wid;
  logic                    tu_valid, tu_ready;
  logic [255:0]            tu_A, tu_B;
  logic [511:0]            tu_C;
  logic [NW-1:0]           tu_wid;
  logic                    tu_rsp_valid, tu_rsp_ready;
  logic [511:0]            tu_rsp_D;
  logic [NW-1:0]           tu_rsp_wid;
  logic [NR-1:0]           rsp_valid, rsp_ready;
  logic [511:0]            rsp_D;
  logic [NW-1:0]           rsp_wid;
  logic                    busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vx_tensor_issue_arb #(.NUM_REQS(NR), .MAX_INFLIGHT(MI), .NW_WIDTH(NW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_A(req_A), .req_B(req_B), .req_C(req_C), .req_wid(req_wid),
    .tu_valid(tu_valid), .tu_ready(tu_ready),
    .tu_A(tu_A), .tu_B(tu_B), .tu_C(tu_C), .tu_wid(tu_wid),
    .tu_rsp_valid(tu_rsp_valid), .tu_rsp_ready(tu_rsp_ready),
    .tu_rsp_D(tu_rsp_D), .tu_rsp_wid(tu_rsp_wid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_D(rsp_D), .rsp_wid(rsp_wid), .busy(busy)
  );

  // Warp ids: requester 0..3 -> 5..8
  task automatic idle_inputs();
    req_valid    = '0;
    req_last     = '0;
    tu_ready     = 1'b1;
    tu_rsp_valid = 1'b0;
    tu_rsp_D     = '0;
    tu_rsp_wid   = '0;
    rsp_ready    = '1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_A[i]   = {8{32'(i)}};
      req_B[i]   = {8{32'(i + 16)}};
      req_C[i]   = {16{32'(i + 32)}};
      req_wid[i] = NW'(i + 5);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready act=%b exp=0000", req_ready); end
    checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL rst_tu_valid act=%b exp=0", tu_valid); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid act=%b exp=0000", rsp_valid); end
    checks++; if (tu_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_tu_rsp_ready act=%b exp=0", tu_rsp_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy act=%b exp=0", busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_requester();
    @(negedge clk);
    req_valid = 4'b0001; req_last = 4'b0000; req_A[0] = {8{32'hA1A1_0001}}; #1;
    checks++; if (tu_valid !== 1'b1) begin errors++; $display("FAIL s1_tu_valid_b0 act=%b exp=1", tu_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL s1_ready_b0 act=%b exp=0001", req_ready); end
    checks++; if (tu_A !== {8{32'hA1A1_0001}}) begin errors++; $display("FAIL s1_tu_A_b0 act=%h exp=%h", tu_A, {8{32'hA1A1_0001}}); end
    checks++; if (tu_wid !== 4'd5) begin errors++; $display("FAIL s1_tu_wid act=%0d exp=5", tu_wid); end
    @(negedge clk);
    req_last = 4'b0001; req_A[0] = {8{32'hA1A1_0002}}; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL s1_ready_b1 act=%b exp=0001", req_ready); end
    checks++; if (tu_A !== {8{32'hA1A1_0002}}) begin errors++; $display("FAIL s1_tu_A_b1 act=%h exp=%h", tu_A, {8{32'hA1A1_0002}}); end
    checks++; if (tu_C !== {16{32'd32}}) begin errors++; $display("FAIL s1_tu_C act=%h exp=%h", tu_C, {16{32'd32}}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL s1_busy_locked act=%b exp=1", busy); end
    @(negedge clk);
    req_valid = 4'b0000; req_last = 4'b0000; #1;
    checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL s1_tu_valid_done act=%b exp=0", tu_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL s1_busy_inflight act=%b exp=1", busy); end
    @(negedge clk);
    tu_rsp_valid = 1'b1; tu_rsp_wid = 4'd5; tu_rsp_D = {16{32'hD00D_0001}}; #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL s1_rsp_valid_d0 act=%b exp=0001", rsp_valid); end
    checks++; if (tu_rsp_ready !== 1'b1) begin errors++; $display("FAIL s1_tu_rsp_ready act=%b exp=1", tu_rsp_ready); end
    checks++; if (rsp_D !== {16{32'hD00D_0001}}) begin errors++; $display("FAIL s1_rsp_D act=%h exp=%h", rsp_D, {16{32'hD00D_0001}}); end
    @(negedge clk);
    tu_rsp_D = {16{32'hD00D_0002}}; #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL s1_rsp_valid_d1 act=%b exp=0001", rsp_valid); end
    checks++; if (rsp_wid !== 4'd5) begin errors++; $display("FAIL s1_rsp_wid act=%0d exp=5", rsp_wid); end
    @(negedge clk);
    tu_rsp_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s1_busy_drained act=%b exp=0", busy); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL s1_rsp_valid_idle act=%b exp=0000", rsp_valid); end
    // rr_ptr is now 1: with 0 and 3 valid, 3 wins
    @(negedge clk);
    req_valid = 4'b1001; req_last = 4'b1001; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL s1_rr_after act=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000; req_last = 4'b0000;
    tu_rsp_valid = 1'b1; tu_rsp_wid = 4'd8; #1;
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL s1_rsp_route3 act=%b exp=1000", rsp_valid); end
    @(negedge clk);
    tu_rsp_valid = 1'b0;
  endtask

  task automatic test_locked_rr();
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_rsp;
    // rr_ptr is 0; requesters 0 and 2 each run 4 beats
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      req_valid = {1'b0, 1'b1, 1'b0, (b < 4)};
      req_last  = {1'b0, (b == 7), 1'b0, (b == 3)};
      if (b >= 1) begin
        tu_rsp_valid = 1'b1;
        tu_rsp_wid   = (b - 1 < 4) ? 4'd5 : 4'd7;
      end else begin
        tu_rsp_valid = 1'b0;
      end
      #1;
      exp_rdy = (b < 4) ? 4'b0001 : 4'b0100;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL lk_ready_b%0d act=%b exp=%b", b, req_ready, exp_rdy); end
      if (b >= 1) begin
        exp_rsp = (b - 1 < 4) ? 4'b0001 : 4'b0100;
        checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL lk_rsp_b%0d act=%b exp=%b", b, rsp_valid, exp_rsp); end
      end
    end
    @(negedge clk);
    req_valid = 4'b0000; req_last = 4'b0000; tu_rsp_wid = 4'd7; #1;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL lk_rsp_tail act=%b exp=0100", rsp_valid); end
    // next pick scans from 3
    @(negedge clk);
    tu_rsp_valid = 1'b0; req_valid = 4'b1001; req_last = 4'b1001; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lk_next_from3 act=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000; req_last = 4'b0000; tu_rsp_valid = 1'b1; tu_rsp_wid = 4'd8;
    @(negedge clk);
    tu_rsp_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lk_busy_drained act=%b exp=0", busy); end
  endtask

  task automatic test_lock_bubble();
    logic [NR-1:0] exp_rsp;
    // rr_ptr is 0
    @(negedge clk);
    req_valid = 4'b0010; req_last = 4'b0000; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bb_first act=%b exp=0010", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b1000; req_last = 4'b1000; #1;
      checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL bb_gap%0d_tu_valid act=%b exp=0", c, tu_valid); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bb_gap%0d_ready act=%b exp=0000", c, req_ready); end
    end
    @(negedge clk);
    req_valid = 4'b1010; req_last = 4'b1010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bb_resume act=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bb_then3 act=%b exp=1000", req_ready); end
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      req_valid = 4'b0000; req_last = 4'b0000;
      tu_rsp_valid = 1'b1; tu_rsp_wid = (r < 2) ? 4'd6 : 4'd8; #1;
      exp_rsp = (r < 2) ? 4'b0010 : 4'b1000;
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL bb_rsp%0d act=%b exp=%b", r, rsp_valid, exp_rsp); end
    end
    @(negedge clk);
    tu_rsp_valid = 1'b0;
  endtask

  task automatic test_credits();
    // rr_ptr is 0; requester 0 runs 6 beats, no responses yet
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      req_valid = 4'b0001; req_last = 4'b0000; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL cr_fire%0d act=%b exp=0001", b, req_ready); end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL cr_full%0d_tu_valid act=%b exp=0", c, tu_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cr_full%0d_busy act=%b exp=1", c, busy); end
    end
    @(negedge clk);
    tu_rsp_valid = 1'b1; tu_rsp_wid = 4'd5; rsp_ready = 4'b0001; #1;
    checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL cr_no_bypass act=%b exp=0", tu_valid); end
    checks++; if (tu_rsp_ready !== 1'b1) begin errors++; $display("FAIL cr_rsp_ready act=%b exp=1", tu_rsp_ready); end
    @(negedge clk);
    tu_rsp_valid = 1'b0; #1;
    checks++; if (tu_valid !== 1'b1) begin errors++; $display("FAIL cr_one_credit act=%b exp=1", tu_valid); end
    @(negedge clk);
    req_last = 4'b0001; #1;
    checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL cr_only_one act=%b exp=0", tu_valid); end
  endtask

  task automatic test_rsp_backpressure();
    logic [NR-1:0] exp_rsp;
    // inflight=4, requester 0 still holds its last beat
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tu_rsp_valid = 1'b1; tu_rsp_wid = 4'd5; rsp_ready = 4'b0000; #1;
      checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL bp%0d_rsp_valid act=%b exp=0001", c, rsp_valid); end
      checks++; if (tu_rsp_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_tu_rsp_ready act=%b exp=0", c, tu_rsp_ready); end
      checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL bp%0d_tu_valid act=%b exp=0", c, tu_valid); end
    end
    @(negedge clk);
    rsp_ready = 4'b0001; #1;
    checks++; if (tu_rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_release act=%b exp=1", tu_rsp_ready); end
    @(negedge clk); #1;
    checks++; if ((tu_valid & tu_rsp_ready) !== 1'b1) begin errors++; $display("FAIL bp_fire_and_rsp act=%b%b exp=11", tu_valid, tu_rsp_ready); end
    @(negedge clk);
    tu_rsp_valid = 1'b0; req_valid = 4'b0100; req_last = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_inflight3 act=%b exp=0100", req_ready); end
    @(negedge clk); #1;
    checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL bp_full_again act=%b exp=0", tu_valid); end
    // drain: heads 0,0,0,2
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      req_valid = 4'b0000; req_last = 4'b0000; rsp_ready = 4'b1111;
      tu_rsp_valid = 1'b1; tu_rsp_wid = (r < 3) ? 4'd5 : 4'd7; #1;
      exp_rsp = (r < 3) ? 4'b0001 : 4'b0100;
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL bp_drain%0d act=%b exp=%b", r, rsp_valid, exp_rsp); end
    end
    @(negedge clk);
    tu_rsp_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_drained act=%b exp=0", busy); end
  endtask

  task automatic test_reset_midop();
    // rr_ptr is 3; requester 1 issues 3 non-last beats and stays locked
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      req_valid = 4'b0010; req_last = 4'b0000; #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mr_fire%0d act=%b exp=0010", b, req_ready); end
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy act=%b exp=0", busy); end
    checks++; if (tu_valid !== 1'b0) begin errors++; $display("FAIL mr_tu_valid act=%b exp=0", tu_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mr_req_ready act=%b exp=0000", req_ready); end
    checks++; if ({rsp_valid, tu_rsp_ready} !== 5'b00000) begin errors++; $display("FAIL mr_rsp act=%b exp=00000", {rsp_valid, tu_rsp_ready}); end
    @(negedge clk);
    reset = 1'b0;
    // lock gone and rr_ptr back at 0: requester 0 beats 3
    @(negedge clk);
    req_valid = 4'b1001; req_last = 4'b1001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mr_rr0 act=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000; req_last = 4'b0000; tu_rsp_valid = 1'b1; tu_rsp_wid = 4'd5; #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL mr_rsp_head act=%b exp=0001", rsp_valid); end
    @(negedge clk);
    tu_rsp_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_inflight_cleared act=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_locked_rr();
    test_lock_bubble();
    test_credits();
    test_rsp_backpressure();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
